// File: rtl/z80_io_pkg.sv
// z80_io_pkg: shared constants and status packing for the z80 I/O port FIFO
package z80_io_pkg;
    localparam int STATUS_OFFSET = 1;
    localparam int TXFULL  = 0;
    localparam int TXEMPTY = 1;
    localparam int RXNE    = 2;
    localparam int RXFULL  = 3;
    localparam int TXOVF   = 6;
    localparam int RXUNF   = 7;
    localparam logic [7:0] RD_EMPTY_VAL = 8'hFF;

    function automatic logic [7:0] pack_status(
        input logic rx_unf,
        input logic tx_ovf,
        input logic rx_full,
        input logic rx_ne,
        input logic tx_empty,
        input logic tx_full
    );
        logic [7:0] s;
        s = '0;
        s[RXUNF]   = rx_unf;
        s[TXOVF]   = tx_ovf;
        s[RXFULL]  = rx_full;
        s[RXNE]    = rx_ne;
        s[TXEMPTY] = tx_empty;
        s[TXFULL]  = tx_full;
        return s;
    endfunction
endpackage

// File: rtl/z80_io_fifo.sv
// z80_io_fifo: synchronous FIFO with wrap-around pointers, occupancy count and flush
module z80_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // advance pointers and occupancy; flush discards everything in flight
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/z80_io_port_fifo.sv
// z80_io_port_fifo: tv80s I/O-mapped DATA/STATUS ports bridging the CPU to TX/RX stream FIFOs
module z80_io_port_fifo
    import z80_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'h00,
    parameter int         DEPTH        = 16,
    parameter bit         WAIT_ON_FULL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    output logic [7:0]  io_di,
    output logic        io_oe,
    output logic        wait_n,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam logic [7:0] STATUS_ADDR = 8'(BASE_ADDR + STATUS_OFFSET);

    logic       serviced_q, serviced_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       rx_unf_q, rx_unf_d;
    logic [7:0] io_di_q, io_di_d;
    logic       is_data, is_stat, sel, wr_cyc, rd_cyc;
    logic       tx_wr, tx_push, tx_drop, tx_stall, st_wr, rx_rd, st_rd;
    logic       tx_full, tx_empty, rx_full, rx_empty, tx_flush;
    logic [7:0] rx_head, status;
    logic       unused_addr;

    assign unused_addr = ^cpu_a[15:8];

    // Only the low address byte is decoded; INTA (M1 with IORQ) never selects us.
    assign is_data = cpu_a[7:0] == BASE_ADDR;
    assign is_stat = cpu_a[7:0] == STATUS_ADDR;
    assign sel     = !cpu_iorq_n && cpu_m1_n && (is_data || is_stat);
    assign wr_cyc  = sel && !cpu_wr_n;
    assign rd_cyc  = sel && !cpu_rd_n;

    // A full TX either stalls the CPU or drops the byte; push only when not full
    // as sampled this clk, so a same-cycle sink pop never lets the byte through early.
    assign tx_wr    = wr_cyc && is_data && !serviced_q;
    assign tx_push  = tx_wr && !tx_full;
    assign tx_stall = tx_wr && tx_full && WAIT_ON_FULL;
    assign tx_drop  = tx_wr && tx_full && !WAIT_ON_FULL;
    assign st_wr    = wr_cyc && is_stat && !serviced_q;
    assign rx_rd    = rd_cyc && is_data && !serviced_q;
    assign st_rd    = rd_cyc && is_stat && !serviced_q;
    assign tx_flush = st_wr && cpu_do[0];

    assign wait_n   = reset || !tx_stall;
    assign io_oe    = rd_cyc;
    assign io_di    = io_di_q;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    z80_io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (tx_flush),
        .push  (tx_push),
        .pop   (tx_ready),
        .din   (cpu_do),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    z80_io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (rx_valid),
        .pop   (rx_rd),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // status snapshot presented on a STATUS read
    always_comb begin
        status = pack_status(rx_unf_q, tx_ovf_q, rx_full, !rx_empty, tx_empty, tx_full);
    end

    // one action per bus cycle, sticky error flags and registered read data
    always_comb begin
        serviced_d = cpu_iorq_n ? 1'b0 : serviced_q;
        tx_ovf_d   = tx_ovf_q;
        rx_unf_d   = rx_unf_q;
        io_di_d    = io_di_q;
        if (tx_push || tx_drop || st_wr || rx_rd || st_rd) serviced_d = 1'b1;
        if (tx_drop) tx_ovf_d = 1'b1;
        if (st_wr && cpu_do[TXOVF]) tx_ovf_d = 1'b0;
        if (st_wr && cpu_do[RXUNF]) rx_unf_d = 1'b0;
        if (rx_rd && rx_empty) rx_unf_d = 1'b1;
        if (rx_rd) io_di_d = rx_empty ? RD_EMPTY_VAL : rx_head;
        if (st_rd) io_di_d = status;
    end

    // control registers; serviced resets high so a cycle spanning reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            serviced_q <= 1'b1;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            io_di_q    <= 8'h00;
        end else begin
            serviced_q <= serviced_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            io_di_q    <= io_di_d;
        end
    end
endmodule

// File: tb/tb_z80_io_port_fifo.sv
// tb_z80_io_port_fifo: directed and randomized bus cycles against a queue-based reference model
module tb_z80_io_port_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic        cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic [7:0]  rx_data;
    logic        iorq_n [2];
    logic        tx_ready [2];
    logic        rx_valid [2];
    logic [7:0]  io_di [2];
    logic        io_oe [2];
    logic        wait_n [2];
    logic [7:0]  tx_data [2];
    logic        tx_valid [2];
    logic        rx_ready [2];

    int checks = 0;
    int errors = 0;
    int u = 0;
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    bit ovf, unf;

    always #5 clk = ~clk;

    z80_io_port_fifo #(.BASE_ADDR(8'h00), .DEPTH(16), .WAIT_ON_FULL(1'b1)) dut (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_iorq_n(iorq_n[0]), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
        .io_di(io_di[0]), .io_oe(io_oe[0]), .wait_n(wait_n[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .rx_data(rx_data), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0])
    );

    z80_io_port_fifo #(.BASE_ADDR(8'h00), .DEPTH(16), .WAIT_ON_FULL(1'b0)) dut_drop (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
        .cpu_iorq_n(iorq_n[1]), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
        .io_di(io_di[1]), .io_oe(io_oe[1]), .wait_n(wait_n[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .rx_data(rx_data), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st_model();
        return {unf, ovf, 2'b00, rxq.size() == 16, rxq.size() != 0, txq.size() == 0, txq.size() == 16};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iorq_n[k] = 1'b1; tx_ready[k] = 1'b0; rx_valid[k] = 1'b0;
        end
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        txq.delete(); rxq.delete(); ovf = 0; unf = 0;
        #1;
        chk("rst_wait_n", 8'(wait_n[u]), 8'h01);
        chk("rst_tx_valid", 8'(tx_valid[u]), 8'h00);
        chk("rst_rx_ready", 8'(rx_ready[u]), 8'h01);
        chk("rst_io_di", io_di[u], 8'h00);
    endtask

    task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_a = {8'h00, addr}; cpu_do = data; cpu_m1_n = 1'b1; iorq_n[u] = 1'b0; cpu_wr_n = 1'b0;
        #1 chk("wr_wait_n", 8'(wait_n[u]), 8'h01);
        chk("wr_io_oe", 8'(io_oe[u]), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        iorq_n[u] = 1'b1; cpu_wr_n = 1'b1;
        if (addr == 8'h00) begin
            if (txq.size() < 16) txq.push_back(data);
            else if (u == 1) ovf = 1;
        end else begin
            if (data[6]) ovf = 0;
            if (data[7]) unf = 0;
            if (data[0]) txq.delete();
        end
    endtask

    task automatic io_rd(input logic [7:0] addr, input logic exp_oe, input logic [7:0] exp,
                         input bit do_push, input logic [7:0] pb);
        @(negedge clk);
        cpu_a = {8'h00, addr}; cpu_m1_n = 1'b1; iorq_n[u] = 1'b0; cpu_rd_n = 1'b0;
        if (do_push) begin rx_valid[u] = 1'b1; rx_data = pb; end
        #1 chk("rd_io_oe", 8'(io_oe[u]), 8'(exp_oe));
        @(negedge clk);
        rx_valid[u] = 1'b0;
        if (exp_oe) chk("rd_io_di", io_di[u], exp);
        @(negedge clk);
        if (exp_oe) chk("rd_io_di_hold", io_di[u], exp);
        iorq_n[u] = 1'b1; cpu_rd_n = 1'b1;
    endtask

    task automatic in_data(input bit do_push, input logic [7:0] pb);
        logic [7:0] e;
        bit can;
        can = rxq.size() < 16;
        if (rxq.size() != 0) e = rxq.pop_front();
        else begin e = 8'hFF; unf = 1; end
        io_rd(8'h00, 1'b1, e, do_push, pb);
        if (do_push && can) rxq.push_back(pb);
    endtask

    task automatic in_status();
        io_rd(8'h01, 1'b1, st_model(), 1'b0, 8'h00);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk);
        chk("rx_ready", 8'(rx_ready[u]), 8'(rxq.size() < 16));
        rx_valid[u] = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid[u] = 1'b0;
        if (rxq.size() < 16) rxq.push_back(b);
    endtask

    task automatic tx_pop();
        @(negedge clk);
        chk("tx_valid", 8'(tx_valid[u]), 8'(txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", tx_data[u], txq[0]);
        tx_ready[u] = 1'b1;
        @(negedge clk);
        tx_ready[u] = 1'b0;
        if (txq.size() != 0) void'(txq.pop_front());
    endtask

    initial begin
        reset = 1'b1; cpu_a = '0; cpu_do = '0; rx_data = '0;
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iorq_n[k] = 1'b1; tx_ready[k] = 1'b0; rx_valid[k] = 1'b0;
        end
        u = 0;
        do_reset();
        in_status();

        // single OUT with the sink stalled: exactly one entry appears
        io_wr(8'h00, 8'h5A);
        repeat (3) @(negedge clk);
        chk("outi_valid", 8'(tx_valid[u]), 8'h01);
        chk("outi_data", tx_data[u], 8'h5A);
        tx_pop();
        tx_pop();

        // TX full stall with WAIT_ON_FULL=1
        for (int i = 0; i < 16; i++) io_wr(8'h00, 8'($urandom));
        @(negedge clk);
        cpu_a = 16'h0000; cpu_do = 8'h3C; iorq_n[u] = 1'b0; cpu_wr_n = 1'b0;
        #1 chk("stall_wait_n", 8'(wait_n[u]), 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", 8'(wait_n[u]), 8'h00);
        end
        chk("stall_head", tx_data[u], txq[0]);
        tx_ready[u] = 1'b1;
        @(negedge clk);
        tx_ready[u] = 1'b0;
        void'(txq.pop_front());
        #1 chk("stall_release", 8'(wait_n[u]), 8'h01);
        @(negedge clk);
        chk("stall_after", 8'(wait_n[u]), 8'h01);
        iorq_n[u] = 1'b1; cpu_wr_n = 1'b1;
        txq.push_back(8'h3C);
        in_status();
        for (int i = 0; i < 17; i++) tx_pop();

        // RX path, underflow, and a foreign port
        rx_push(8'hA5);
        rx_push(8'h5A);
        in_data(1'b0, 8'h00);
        in_data(1'b0, 8'h00);
        in_data(1'b0, 8'h00);
        in_status();
        rx_push(8'h11);
        io_rd(8'h02, 1'b0, 8'h00, 1'b0, 8'h00);
        in_data(1'b0, 8'h00);
        io_wr(8'h01, 8'h80);
        in_status();

        // long read cycle performs a single pop
        rx_push(8'h11);
        rx_push(8'h22);
        @(negedge clk);
        cpu_a = 16'h0000; iorq_n[u] = 1'b0; cpu_rd_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("long_rd_di", io_di[u], 8'h11);
            chk("long_rd_oe", 8'(io_oe[u]), 8'h01);
        end
        iorq_n[u] = 1'b1; cpu_rd_n = 1'b1;
        void'(rxq.pop_front());
        in_status();
        in_data(1'b0, 8'h00);

        // interrupt acknowledge cycles are ignored
        rx_push(8'h33);
        @(negedge clk);
        cpu_a = 16'h0000; cpu_m1_n = 1'b0; iorq_n[u] = 1'b0; cpu_rd_n = 1'b0;
        #1 chk("inta_oe", 8'(io_oe[u]), 8'h00);
        repeat (3) @(negedge clk);
        cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_do = 8'h44;
        repeat (3) @(negedge clk);
        iorq_n[u] = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        tx_pop();
        in_data(1'b0, 8'h00);

        // RX full with a same-cycle pop: the offered byte is refused
        while (rxq.size() < 16) rx_push(8'($urandom));
        in_data(1'b1, 8'h77);
        in_status();
        in_data(1'b1, 8'h99);
        for (int i = 0; i < 17; i++) in_data(1'b0, 8'h00);
        io_wr(8'h01, 8'hC0);

        // randomized mix of bus cycles and stream traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    if (txq.size() == 16) tx_pop();
                    io_wr(8'h00, 8'($urandom));
                end
                1: in_data($urandom_range(0, 1) == 1, 8'($urandom));
                2: in_status();
                3: io_wr(8'h01, 8'($urandom));
                4: rx_push(8'($urandom));
                default: tx_pop();
            endcase
        end

        // reset in the middle of a stalled OUT
        do_reset();
        for (int i = 0; i < 16; i++) io_wr(8'h00, 8'($urandom));
        @(negedge clk);
        cpu_a = 16'h0000; cpu_do = 8'h3C; iorq_n[u] = 1'b0; cpu_wr_n = 1'b0;
        #1 chk("rstmid_stall", 8'(wait_n[u]), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rstmid_wait_n", 8'(wait_n[u]), 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        txq.delete(); rxq.delete(); ovf = 0; unf = 0;
        #1 chk("rstmid_wait_rel", 8'(wait_n[u]), 8'h01);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_wait_hold", 8'(wait_n[u]), 8'h01);
            chk("rstmid_tx_valid", 8'(tx_valid[u]), 8'h00);
        end
        iorq_n[u] = 1'b1; cpu_wr_n = 1'b1;
        in_status();
        tx_pop();

        // overflow drop with WAIT_ON_FULL=0
        u = 1;
        do_reset();
        for (int i = 0; i < 16; i++) io_wr(8'h00, 8'($urandom));
        io_wr(8'h00, 8'h3C);
        in_status();
        chk("ovf_status", st_model(), 8'h41);
        io_wr(8'h01, 8'h40);
        in_status();
        for (int i = 0; i < 17; i++) tx_pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_io_port_fifo.md
Name: z80_io_port_fifo

Overview:
- I/O-mapped peripheral that answers tv80s I/O cycles (OUT/OUTI/IN/INI) on the CPU bus.
- CPU writes to the DATA port push into a TX FIFO that drains to a stream sink.
- CPU reads from the DATA port pop an RX FIFO that is filled from a stream source. A STATUS port reports levels and sticky error flags.
- Instantiated beside the tb memory/IO model. The top-level muxes io_di onto cpu_di when io_oe=1.

Parameters:
- BASE_ADDR, 8'h00, DATA port address. STATUS is at BASE_ADDR+1, mod 256.
- DEPTH, 16, entries per FIFO. Power of 2, from 2 to 256.
- WAIT_ON_FULL, 1. 1: a write to a full TX FIFO stretches the cycle with wait_n. 0: the write is dropped and the overflow flag is set.

Ports:
- clk  in  1  system clock (the tv80s clk)
- reset  in  1  synchronous, active-high
- cpu_a  in  16  address bus; only [7:0] is decoded
- cpu_do  in  8  CPU write data
- cpu_iorq_n  in  1  I/O request, active-low
- cpu_rd_n  in  1  read strobe, active-low
- cpu_wr_n  in  1  write strobe, active-low
- cpu_m1_n  in  1  when low with iorq_n low, marks an interrupt acknowledge, which is ignored
- io_di  out  8  read data to the CPU
- io_oe  out  1  high while this block drives io_di
- wait_n  out  1  to cpu wait_n, active-low
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  sink accepts; pop on tx_valid&&tx_ready
- rx_data  in  8  source data
- rx_valid  in  1  source offers data
- rx_ready  out  1  RX FIFO not full; push on rx_valid&&rx_ready

Behaviour:
- Bus cycle decode
  - sel = !iorq_n && m1_n && (a[7:0]==BASE_ADDR || a[7:0]==BASE_ADDR+1).
  - wr_cyc = sel&&!wr_n. rd_cyc = sel&&!rd_n.
- One action per bus cycle
  - A `serviced` flop is set when an action is taken and cleared on the first clk with iorq_n=1.
  - An action happens only while serviced=0.
- TX write (wr_cyc, DATA, serviced=0)
  - TX not full: push cpu_do, set serviced.
  - TX full with WAIT_ON_FULL=1: wait_n=0 (combinational) until a pop frees space. The push occurs on the first clk where full=0 is sampled before that cycle's pop (no same-cycle push-through when full).
  - TX full with WAIT_ON_FULL=0: drop the byte, set tx_ovf, set serviced.
- STATUS write
  - bit6=1 clears tx_ovf; bit7=1 clears rx_unf; bit0=1 flushes TX.
  - Sets serviced.
- RX read (rd_cyc, DATA, serviced=0)
  - Non-empty: io_di<=head and pop, registered. The value is valid from the next clk and held until iorq_n=1.
  - Empty: io_di<=8'hFF, set rx_unf.
  - Either way, set serviced.
- STATUS read
  - io_di <= {rx_unf, tx_ovf, 2'b0, rx_full, rx_nonempty, tx_empty, tx_full}, sampled at the first clk; sets serviced.
- io_oe = rd_cyc (combinational). It stays 0 for other ports, M1 cycles and writes.
- Read latency
  - io_di is valid 1 clk after rd_n falls.
  - tv80 I/O cycles hold rd_n low for at least 2 clk (T2+TW), which is sufficient.
- FIFOs
  - Each FIFO has wrap-around pointers plus a count of width $clog2(DEPTH)+1.
  - Simultaneous push and pop when non-empty and not full: count unchanged.
  - RX: external push and CPU pop in the same clk are both honoured.
  - rx_ready=0 when RX is full, including when a pop happens the same cycle.
- Reset
  - Both FIFOs empty, tx_ovf=rx_unf=0, io_di=8'h00.
  - wait_n=1, tx_valid=0, rx_ready=1.
  - serviced=1, so an I/O cycle in progress across reset is ignored until iorq_n returns high.
- wait_n is 1 in all cases other than the TX-full stall. Reset forces it to 1 immediately.

Decomposition:
- Package z80_io_pkg holds:
  - localparams STATUS_OFFSET=1
  - status bit indices TXFULL=0, TXEMPTY=1, RXNE=2, RXFULL=3, TXOVF=6, RXUNF=7
  - RD_EMPTY_VAL=8'hFF
- Sub-module z80_io_fifo (synchronous FIFO, params WIDTH and DEPTH) is instantiated twice: TX and RX.

Test Plan:
- OUTI via tv80s
  - Stimulus: port BASE_ADDR=00, B=08, C=00, HL=01FE, mem[01FE]=5A; run ED A3.
  - Required: exactly one push, tx_data=5A, tx_valid=1 with tx_ready=0, B=07, HL=01FF.
- TX full stall, WAIT_ON_FULL=1
  - Stimulus: fill 16 entries, issue a 17th OUT of 3C.
  - Required: wait_n=0 and the CPU holds.
  - Then pulse tx_ready for 1 clk: wait_n=1 on the next clk, 3C becomes the last entry, count=16.
- TX overflow, WAIT_ON_FULL=0
  - Stimulus: 17th OUT of 3C.
  - Required: byte dropped; STATUS read = 8'h41.
  - Then OUT 8'h40 to STATUS: next STATUS read = 8'h01.
- RX path
  - Stimulus: push A5 then 5A from the source, then IN A,(00) twice.
  - Required: A=A5 then 5A.
  - A third IN returns FF and STATUS bit7=1. io_oe=0 during an IN from port 02.
- Single action per cycle
  - Stimulus: hold iorq_n/rd_n low for 4 clk on DATA with RX holding 11,22.
  - Required: only one pop; io_di=11 throughout.
  - Also: an M1+IORQ (INTA) cycle pushes and pops nothing.
- Reset mid-cycle
  - Stimulus: assert reset for 2 clk during an OUT with TX full.
  - Required: wait_n=1, FIFOs empty, and no push for that OUT after reset releases.
